// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types, constants and the priority region decoder
// for the CPU bus fabric.
package cpu_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } bus_state_e;

  // Width of the per-slave wait-state count (0..7 waits).
  localparam int WCNT_W = 3;

  // Read data returned for unmapped or timed-out reads.
  localparam logic [7:0] UNMAP_DATA_DEF = 8'hff;

  // The decoder works on a fixed-size region table so one function serves
  // every parameterisation; unused entries are masked off by the slave count.
  localparam int MAX_SLV   = 32;
  localparam int MAX_SEL_W = 8;
  localparam int IDX_W     = 5;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } decode_t;

  // Priority decode: the lowest-index slave whose region code matches wins.
  function automatic decode_t prio_decode(
    input logic [MAX_SEL_W-1:0]         code,
    input logic [MAX_SLV*MAX_SEL_W-1:0] base,
    input int                           nslv
  );
    decode_t res;
    res = '0;
    // Walk downwards so the last match recorded is the lowest index.
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < nslv && base[i*MAX_SEL_W +: MAX_SEL_W] == code) begin
        res.hit = 1'b1;
        res.idx = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_bus_fabric_wait.sv
// bus_wait_ctr: wait-state sequencer for one CPU access. Produces CPU
// ready and a one-cycle "complete" pulse when the addressed slave may be
// strobed. With SLAVE_STALL_EN defined it also honours the slave stall
// request and aborts the access after TIMEOUT cycles.
module bus_wait_ctr
  import cpu_bus_pkg::*;
`ifdef SLAVE_STALL_EN
#(
  parameter int TIMEOUT = 64
)
`endif
(
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_mapped,
  input  logic [WCNT_W-1:0] wait_n,
`ifdef SLAVE_STALL_EN
  input  logic              stall,
  output logic              timeout,
`endif
  output logic              rdy,
  output logic              complete
);

  bus_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

`ifdef SLAVE_STALL_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              tmo_hit;

  // tcnt holds the number of cycles the CPU has already been held off.
  assign tmo_hit = (tcnt_q >= TCNT_W'(TIMEOUT));
`endif

  // Next-state, wait countdown and ready/complete generation.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rdy      = 1'b1;
    complete = 1'b0;
`ifdef SLAVE_STALL_EN
    tcnt_d   = tcnt_q;
    timeout  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (acc_mapped) begin
          if (wait_n != '0) begin
            rdy     = 1'b0;
            wcnt_d  = wait_n - 1'b1;
            state_d = ST_WAIT;
`ifdef SLAVE_STALL_EN
            tcnt_d  = TCNT_W'(1);
`endif
          end
`ifdef SLAVE_STALL_EN
          else if (stall) begin
            rdy     = 1'b0;
            wcnt_d  = '0;
            state_d = ST_WAIT;
            tcnt_d  = TCNT_W'(1);
          end
`endif
          else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q != '0) begin
          rdy    = 1'b0;
          wcnt_d = wcnt_q - 1'b1;
`ifdef SLAVE_STALL_EN
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
`ifdef SLAVE_STALL_EN
        else if (tmo_hit) begin
          // Give up on the slave: release the CPU without a strobe.
          timeout = 1'b1;
          tcnt_d  = '0;
          state_d = ST_IDLE;
        end
        else if (stall) begin
          rdy    = 1'b0;
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
        else begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
`ifdef SLAVE_STALL_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
`ifdef SLAVE_STALL_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

endmodule

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: table-driven address decode, per-slave wait states,
// single-shot slave strobes, read-data return mux and an unmapped-access
// error counter between the 6502-family CPU and NSLV slaves.
// Optional: define SLAVE_STALL_EN to add the slv_stall input and the
// TIMEOUT parameter (stall extension with access timeout).
module cpu_bus_fabric
  import cpu_bus_pkg::*;
#(
  parameter int                     NSLV       = 4,
  parameter int                     AW         = 16,
  parameter int                     DW         = 8,
  parameter int                     SEL_W      = 4,
  parameter logic [NSLV*SEL_W-1:0]  SLV_BASE   = {4'hf, 4'h2, 4'h1, 4'h0},
  parameter logic [NSLV*WCNT_W-1:0] SLV_WAIT   = '0,
  parameter logic [DW-1:0]          UNMAP_DATA = DW'(UNMAP_DATA_DEF)
`ifdef SLAVE_STALL_EN
  ,
  parameter int                     TIMEOUT    = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_ab,
  input  logic               cpu_we,
  input  logic [DW-1:0]      cpu_do,
  output logic [DW-1:0]      cpu_di,
  output logic               cpu_rdy,
  output logic [NSLV-1:0]    slv_cs,
  output logic [NSLV-1:0]    slv_re,
  output logic [NSLV-1:0]    slv_we,
  output logic [AW-1:0]      slv_ab,
  output logic [DW-1:0]      slv_din,
  input  logic [NSLV*DW-1:0] slv_dout,
`ifdef SLAVE_STALL_EN
  input  logic [NSLV-1:0]    slv_stall,
`endif
  input  logic               err_clr,
  output logic [7:0]         err_cnt
);

  logic [MAX_SLV*MAX_SEL_W-1:0] base_ext;
  decode_t                      dec;
  logic [WCNT_W-1:0]            wait_n;
  logic                         complete;
  logic                         tmo;
  logic                         strobe_en;
  logic                         err_inc;
  logic [DW-1:0]                dout_sel;
  logic                         sel_unmap_q, sel_unmap_d;
  logic [IDX_W-1:0]             sel_idx_q, sel_idx_d;
  logic [7:0]                   err_q, err_d;

  // Widen the region table into the decoder's fixed layout.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_SLV; gi++) begin : g_base
      if (gi < NSLV) begin : g_used
        assign base_ext[gi*MAX_SEL_W +: MAX_SEL_W] =
          MAX_SEL_W'(SLV_BASE[gi*SEL_W +: SEL_W]);
      end else begin : g_unused
        assign base_ext[gi*MAX_SEL_W +: MAX_SEL_W] = '0;
      end
    end
  endgenerate

  assign dec = prio_decode(MAX_SEL_W'(cpu_ab[AW-1 -: SEL_W]), base_ext, NSLV);

  // One-hot chip select from the winning slave index.
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_cs
      assign slv_cs[gi] = dec.hit & (dec.idx == IDX_W'(gi));
    end
  endgenerate

  // Wait-state count of the selected slave.
  always_comb begin
    wait_n = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_cs[i]) wait_n = SLV_WAIT[i*WCNT_W +: WCNT_W];
    end
  end

`ifdef SLAVE_STALL_EN
  logic stall_sel;

  // Stall request of the selected slave only.
  always_comb begin
    stall_sel = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (slv_cs[i]) stall_sel = slv_stall[i];
    end
  end

  bus_wait_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .acc_mapped(dec.hit),
    .wait_n    (wait_n),
    .stall     (stall_sel),
    .timeout   (tmo),
    .rdy       (cpu_rdy),
    .complete  (complete)
  );
`else
  assign tmo = 1'b0;

  bus_wait_ctr u_wait (
    .clk       (clk),
    .reset     (reset),
    .acc_mapped(dec.hit),
    .wait_n    (wait_n),
    .rdy       (cpu_rdy),
    .complete  (complete)
  );
`endif

  // Strobes fire only on the completing cycle of a mapped access.
  assign strobe_en = complete & ~reset;
  assign slv_re    = slv_cs & {NSLV{strobe_en & ~cpu_we}};
  assign slv_we    = slv_cs & {NSLV{strobe_en &  cpu_we}};
  assign slv_ab    = cpu_ab;
  assign slv_din   = cpu_do;

  // Remember which slave the last completed access addressed.
  always_comb begin
    sel_unmap_d = ~dec.hit | tmo;
    sel_idx_d   = dec.idx;
  end

  // Read-return select register, updated on every completing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_unmap_q <= 1'b1;
      sel_idx_q   <= '0;
    end else if (cpu_rdy) begin
      sel_unmap_q <= sel_unmap_d;
      sel_idx_q   <= sel_idx_d;
    end
  end

  // Read-data mux driven from the registered selection.
  always_comb begin
    dout_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_idx_q == IDX_W'(i)) dout_sel = slv_dout[i*DW +: DW];
    end
  end

  assign cpu_di = sel_unmap_q ? UNMAP_DATA : dout_sel;

  // Saturating error count; a clear wins over a simultaneous increment.
  always_comb begin
    err_inc = cpu_rdy & (~dec.hit | tmo);
    err_d   = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (err_inc && err_q != 8'hff) begin
      err_d = err_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb_cpu_bus_fabric: randomized self-checking bench for cpu_bus_fabric.
// Five slaves: codes {0,1,2,1,8} (slave 3 overlaps slave 1), waits
// {0,0,3,7,5}. Stall scenarios are built when SLAVE_STALL_EN is defined.
`timescale 1ns/1ps
module tb_cpu_bus_fabric;

  localparam int NS = 5;
`ifdef SLAVE_STALL_EN
  localparam int TIMEOUT = 64;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [15:0]      cpu_ab;
  logic             cpu_we;
  logic [7:0]       cpu_do;
  logic [7:0]       cpu_di;
  logic             cpu_rdy;
  logic [NS-1:0]    slv_cs, slv_re, slv_we;
  logic [15:0]      slv_ab;
  logic [7:0]       slv_din;
  logic [NS*8-1:0]  slv_dout;
  logic             err_clr;
  logic [7:0]       err_cnt;
`ifdef SLAVE_STALL_EN
  logic [NS-1:0]    slv_stall;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference: region codes and wait counts per slave.
  int codes [NS] = '{0, 1, 2, 1, 8};
  int waits [NS] = '{0, 0, 3, 7, 5};

  logic [7:0] smem   [NS][256];
  logic [7:0] shadow [NS][256];
  logic [7:0] sdout  [NS];

  int         err_model;
  bit         pend_valid;
  logic [7:0] pend_data;

  cpu_bus_fabric #(
    .NSLV      (NS),
    .AW        (16),
    .DW        (8),
    .SEL_W     (4),
    .SLV_BASE  ({4'h8, 4'h1, 4'h2, 4'h1, 4'h0}),
    .SLV_WAIT  ({3'd5, 3'd7, 3'd3, 3'd0, 3'd0}),
    .UNMAP_DATA(8'hff)
`ifdef SLAVE_STALL_EN
    , .TIMEOUT (TIMEOUT)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_ab   (cpu_ab),
    .cpu_we   (cpu_we),
    .cpu_do   (cpu_do),
    .cpu_di   (cpu_di),
    .cpu_rdy  (cpu_rdy),
    .slv_cs   (slv_cs),
    .slv_re   (slv_re),
    .slv_we   (slv_we),
    .slv_ab   (slv_ab),
    .slv_din  (slv_din),
    .slv_dout (slv_dout),
`ifdef SLAVE_STALL_EN
    .slv_stall(slv_stall),
`endif
    .err_clr  (err_clr),
    .err_cnt  (err_cnt)
  );

  // Slave models: synchronous read data, write on strobe.
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (slv_re[s]) sdout[s] <= smem[s][slv_ab[7:0]];
      if (slv_we[s]) smem[s][slv_ab[7:0]] <= slv_din;
    end
  end

  always_comb begin
    slv_dout = '0;
    for (int s = 0; s < NS; s++) slv_dout[s*8 +: 8] = sdout[s];
  end

  // Reference decode: first slave whose code matches the top nibble.
  function automatic int winner(input logic [15:0] a);
    for (int i = 0; i < NS; i++) begin
      if (codes[i] == int'(a[15:12])) return i;
    end
    return -1;
  endfunction

  // One complete CPU access, checked against the reference model.
  task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                           input logic clr, input int stall_len, input string name);
    int w, exp_low, low, cyc, nre, nwe, cs_bad, exp_re, exp_we;
    bit done, tmo, exp_strobe, strobe_ok;
    logic [NS-1:0] exp_cs;
    w = winner(a);
    exp_cs  = '0;
    exp_low = 0;
    tmo     = 1'b0;
    if (w >= 0) begin
      exp_cs[w] = 1'b1;
      exp_low   = waits[w];
`ifdef SLAVE_STALL_EN
      if (stall_len > exp_low) exp_low = stall_len;
      if (exp_low >= TIMEOUT) begin
        exp_low = TIMEOUT;
        tmo     = 1'b1;
      end
`endif
    end
    exp_strobe = (w >= 0) && !tmo;
    exp_re = (exp_strobe && !we) ? 1 : 0;
    exp_we = (exp_strobe &&  we) ? 1 : 0;

    @(negedge clk);
    cpu_ab  = a;
    cpu_we  = we;
    cpu_do  = d;
    err_clr = clr;
    low = 0; cyc = 0; nre = 0; nwe = 0; cs_bad = 0;
    done = 1'b0; strobe_ok = 1'b0;
    while (!done && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
`ifdef SLAVE_STALL_EN
      slv_stall = NS'($urandom);
      if (w >= 0) slv_stall[w] = (cyc < stall_len);
`endif
      #1;
      if (cyc == 0) begin
        if (pend_valid) begin
          checks++;
          if (cpu_di !== pend_data) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, cpu_di, pend_data);
          end
        end
        checks++;
        if (err_cnt !== 8'(err_model)) begin
          failures++;
          $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, err_model);
        end
      end
      if (slv_cs !== exp_cs) cs_bad++;
      nre += $countones(slv_re);
      nwe += $countones(slv_we);
      if (cpu_rdy === 1'b1) begin
        done = 1'b1;
        if (exp_strobe) begin
          if (we) strobe_ok = (slv_we === exp_cs) && (slv_re === '0) && (slv_din === d);
          else    strobe_ok = (slv_re === exp_cs) && (slv_we === '0) && (slv_ab === a);
        end
      end else begin
        low++;
      end
      @(posedge clk);
      cyc++;
    end

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s bound: cpu_rdy stayed low for %0d cycles, want completion", name, cyc);
    end
    checks++;
    if (cs_bad != 0) begin
      failures++;
      $display("FAIL %s slv_cs: %0d cycles got %b want %b", name, cs_bad, slv_cs, exp_cs);
    end
    checks++;
    if (low != exp_low) begin
      failures++;
      $display("FAIL %s rdy_low: got %0d cycles want %0d", name, low, exp_low);
    end
    checks++;
    if (nre != exp_re || nwe != exp_we) begin
      failures++;
      $display("FAIL %s strobes: got re=%0d we=%0d want re=%0d we=%0d", name, nre, nwe, exp_re, exp_we);
    end
    if (exp_strobe) begin
      checks++;
      if (!strobe_ok) begin
        failures++;
        $display("FAIL %s strobe_cycle: got re=%b we=%b din=%h want slave %0d din=%h", name, slv_re, slv_we, slv_din, w, d);
      end
    end

    if (clr) err_model = 0;
    else if (w < 0 || tmo) err_model = (err_model == 255) ? 255 : err_model + 1;

    if (!we) begin
      pend_valid = 1'b1;
      pend_data  = exp_strobe ? shadow[w][a[7:0]] : 8'hff;
    end else if (exp_strobe) begin
      shadow[w][a[7:0]] = d;
      pend_valid = 1'b0;
    end else begin
      pend_valid = 1'b1;
      pend_data  = 8'hff;
    end

    $display("txn %-14s addr=%h we=%0d do=%h slave=%0d low=%0d tmo=%0d err=%0d",
             name, a, we, d, w, low, tmo, err_model);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy: got %b want 1", cpu_rdy);
    end
    checks++;
    if (slv_re !== '0 || slv_we !== '0 || slv_cs !== '0) begin
      failures++;
      $display("FAIL reset_strobes: got cs=%b re=%b we=%b want all 0", slv_cs, slv_re, slv_we);
    end
    checks++;
    if (cpu_di !== 8'hff) begin
      failures++;
      $display("FAIL reset_di: got %h want ff", cpu_di);
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_err: got %0d want 0", err_cnt);
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    err_model  = 0;
    pend_valid = 1'b1;
    pend_data  = 8'hff;
    $display("txn %-14s held 3 cycles on unmapped read", "reset");
  endtask

  task automatic test_basic();
    do_access(16'h0123, 1'b0, 8'h00, 1'b0, 0, "rd_s0_w0");
    do_access(16'h2000, 1'b1, 8'h41, 1'b0, 0, "wr_s2_w3");
    do_access(16'h2000, 1'b0, 8'h00, 1'b0, 0, "rd_s2_back");
    do_access(16'h5000, 1'b0, 8'h00, 1'b0, 0, "rd_unmapped");
    do_access(16'h8042, 1'b1, 8'h9c, 1'b0, 0, "wr_s4_w5");
    do_access(16'h8042, 1'b0, 8'h00, 1'b0, 0, "rd_s4_back");
    do_access(16'h7777, 1'b1, 8'h12, 1'b0, 0, "wr_unmapped");
  endtask

  task automatic test_overlap();
    do_access(16'h1abc, 1'b1, 8'h77, 1'b0, 0, "ovl_wr");
    do_access(16'h1abc, 1'b0, 8'h00, 1'b0, 0, "ovl_rd");
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] nd;
    do_access(16'h6000, 1'b0, 8'h00, 1'b0, 0, "pre_rst_unmap");
    nd = ~shadow[2][8'haa];
    @(negedge clk);
    cpu_ab  = 16'h20aa;
    cpu_we  = 1'b1;
    cpu_do  = nd;
    err_clr = 1'b0;
`ifdef SLAVE_STALL_EN
    slv_stall = '0;
`endif
    #1;
    if (pend_valid) begin
      checks++;
      if (cpu_di !== pend_data) begin
        failures++;
        $display("FAIL rst_pre_rd: got %h want %h", cpu_di, pend_data);
      end
    end
    checks++;
    if (cpu_rdy !== 1'b0 || slv_we !== '0) begin
      failures++;
      $display("FAIL rst_wait_c1: got rdy=%b we=%b want rdy=0 we=0", cpu_rdy, slv_we);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (slv_we !== '0 || slv_re !== '0) begin
      failures++;
      $display("FAIL rst_abort_strobe: got re=%b we=%b want 0", slv_re, slv_we);
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    err_model  = 0;
    pend_valid = 1'b1;
    pend_data  = 8'hff;
    $display("txn %-14s reset in 2nd cycle of 3-wait write", "rst_mid_wait");
    do_access(16'h0000, 1'b0, 8'h00, 1'b0, 0, "post_rst_rd");
    do_access(16'h20aa, 1'b0, 8'h00, 1'b0, 0, "rst_nowrite");
  endtask

`ifdef SLAVE_STALL_EN
  task automatic test_stall();
    do_access(16'h1005, 1'b0, 8'h00, 1'b0, 200, "stall_tmo_rd");
    do_access(16'h1006, 1'b0, 8'h00, 1'b0, 4,   "stall_rel5");
    do_access(16'h2010, 1'b1, 8'h5a, 1'b0, 2,   "stall_lt_wait");
    do_access(16'h2010, 1'b0, 8'h00, 1'b0, 6,   "stall_gt_wait");
    do_access(16'h1007, 1'b1, 8'h33, 1'b0, 200, "stall_tmo_wr");
    do_access(16'h1007, 1'b0, 8'h00, 1'b0, 0,   "tmo_wr_dropped");
  endtask
`endif

  task automatic test_random();
    logic [3:0]  top;
    logic [15:0] a;
    int          sl;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0:       top = 4'h0;
        1:       top = 4'h1;
        2:       top = 4'h2;
        3:       top = 4'h8;
        default: top = 4'($urandom_range(0, 15));
      endcase
      a  = {top, 4'($urandom), 8'($urandom_range(0, 15))};
      sl = 0;
`ifdef SLAVE_STALL_EN
      case ($urandom_range(0, 5))
        0:       sl = 100;
        1, 2:    sl = $urandom_range(1, 10);
        default: sl = 0;
      endcase
`endif
      do_access(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, sl, "random");
    end
  endtask

  task automatic test_err_sat();
    for (int n = 0; n < 300; n++) begin
      do_access({4'h5, 12'($urandom)}, 1'b0, 8'h00, 1'b0, 0, "unmap_sat");
    end
    do_access(16'h5000, 1'b0, 8'h00, 1'b1, 0, "err_clr_unmap");
    do_access(16'h9000, 1'b0, 8'h00, 1'b0, 0, "after_clr");
  endtask

  task automatic test_flush();
    @(negedge clk);
    #1;
    if (pend_valid) begin
      checks++;
      if (cpu_di !== pend_data) begin
        failures++;
        $display("FAIL flush_rdata: got %h want %h", cpu_di, pend_data);
      end
    end
    checks++;
    if (err_cnt !== 8'(err_model)) begin
      failures++;
      $display("FAIL flush_err: got %0d want %0d", err_cnt, err_model);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cpu_ab  = 16'h5000;
    cpu_we  = 1'b0;
    cpu_do  = 8'h00;
    err_clr = 1'b0;
`ifdef SLAVE_STALL_EN
    slv_stall = '0;
`endif
    err_model  = 0;
    pend_valid = 1'b0;
    pend_data  = 8'hff;
    for (int s = 0; s < NS; s++) begin
      sdout[s] = 8'h00;
      for (int i = 0; i < 256; i++) begin
        smem[s][i]   = 8'($urandom);
        shadow[s][i] = smem[s][i];
      end
    end

    test_reset();
    test_basic();
    test_overlap();
    test_reset_mid_wait();
`ifdef SLAVE_STALL_EN
    test_stall();
`endif
    test_random();
    test_err_sat();
    test_flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
